// File: rtl/d_reg_scoreboard.sv
// d_reg_scoreboard
// D-stage operand reader. Drives the GRF read addresses, tracks outstanding
// destination writes per register, stalls on pending sources, bypasses the
// same-cycle write-back value and hands a registered operand packet to the
// E stage over a valid/ready handshake.
//
// Optional build macro: SCOREBOARD_CHECK_EN
//   defined   : sb_err flags a write-back to a register with no outstanding
//               reservation (sticky until reset), plus a simulation message.
//   undefined : sb_err is tied to 0.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   in_valid/in_ready   decoded instruction handshake
//   rs_addr/rt_addr     source registers, rs_use/rt_use source enables
//   dst_addr/dst_we     destination register and its write enable
//   A1/A2, RD1/RD2      GRF read port
//   wb_we/wb_addr/wb_data  GRF write port (observed, not driven)
//   out_valid/out_ready operand packet handshake to E
//   out_rs_val/out_rt_val/out_dst/out_dst_we  operand packet
//   sb_err              scoreboard underflow flag
module d_reg_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic        rs_use,
   input  logic        rt_use,
   input  logic [4:0]  dst_addr,
   input  logic        dst_we,
   output logic [4:0]  A1,
   output logic [4:0]  A2,
   input  logic [31:0] RD1,
   input  logic [31:0] RD2,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rs_val,
   output logic [31:0] out_rt_val,
   output logic [4:0]  out_dst,
   output logic        out_dst_we,
   output logic        sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];

   logic        out_valid_q,  out_valid_d;
   logic [31:0] out_rs_val_q, out_rs_val_d;
   logic [31:0] out_rt_val_q, out_rt_val_d;
   logic [4:0]  out_dst_q,    out_dst_d;
   logic        out_dst_we_q, out_dst_we_d;

   logic             wb_fire;
   logic [CNT_W-1:0] rs_cnt, rt_cnt, dst_cnt;
   logic             rs_hazard, rt_hazard, full_hazard;
   logic             accept;
   logic             inc_en;
   logic [31:0]      rs_val, rt_val;

   assign A1 = rs_addr;
   assign A2 = rt_addr;

   always_comb begin
      wb_fire = wb_we && (wb_addr != 5'd0);
      rs_cnt  = cnt_q[rs_addr];
      rt_cnt  = cnt_q[rt_addr];
      dst_cnt = cnt_q[dst_addr];

      // A source whose only outstanding writer is retiring this cycle is
      // served from the bypass instead of stalling.
      rs_hazard = rs_use && (rs_addr != 5'd0) && (rs_cnt != '0) &&
                  !(wb_fire && (wb_addr == rs_addr) && (rs_cnt == CNT_ONE));
      rt_hazard = rt_use && (rt_addr != 5'd0) && (rt_cnt != '0) &&
                  !(wb_fire && (wb_addr == rt_addr) && (rt_cnt == CNT_ONE));
      // A saturated counter may take a new reservation only if one retires
      // in the same cycle, so the count never overflows.
      full_hazard = dst_we && (dst_addr != 5'd0) && (dst_cnt == CNT_MAX) &&
                    !(wb_fire && (wb_addr == dst_addr));

      in_ready = !rs_hazard && !rt_hazard && !full_hazard &&
                 (!out_valid_q || out_ready);
      accept   = in_valid && in_ready;
      inc_en   = accept && dst_we && (dst_addr != 5'd0);

      // GRF commits on the edge, so a same-cycle write is not yet in RDx.
      rs_val = (wb_we && (wb_addr == rs_addr) && (rs_addr != 5'd0)) ? wb_data : RD1;
      rt_val = (wb_we && (wb_addr == rt_addr) && (rt_addr != 5'd0)) ? wb_data : RD2;
   end

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (inc_en && (dst_addr == 5'(r)) &&
                      !(wb_fire && (wb_addr == 5'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (wb_fire && (wb_addr == 5'(r)) &&
                      !(inc_en && (dst_addr == 5'(r))) && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_rs_val_d = out_rs_val_q;
      out_rt_val_d = out_rt_val_q;
      out_dst_d    = out_dst_q;
      out_dst_we_d = out_dst_we_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_rs_val_d = rs_val;
         out_rt_val_d = rt_val;
         out_dst_d    = dst_addr;
         out_dst_we_d = dst_we;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         out_valid_q  <= 1'b0;
         out_rs_val_q <= 32'd0;
         out_rt_val_q <= 32'd0;
         out_dst_q    <= 5'd0;
         out_dst_we_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_rs_val_q <= out_rs_val_d;
         out_rt_val_q <= out_rt_val_d;
         out_dst_q    <= out_dst_d;
         out_dst_we_q <= out_dst_we_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_rs_val = out_rs_val_q;
   assign out_rt_val = out_rt_val_q;
   assign out_dst    = out_dst_q;
   assign out_dst_we = out_dst_we_q;

`ifdef SCOREBOARD_CHECK_EN
   logic sb_err_q, sb_err_d;
   logic underflow;

   always_comb begin
      // A reservation made in the same cycle covers the retiring write.
      underflow = wb_fire && (cnt_q[wb_addr] == '0) &&
                  !(inc_en && (dst_addr == wb_addr));
      sb_err_d  = sb_err_q || underflow;
   end

   always_ff @(posedge clk) begin
      if (!reset) sb_err_q <= 1'b0;
      else        sb_err_q <= sb_err_d;
   end

   assign sb_err = sb_err_q;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && underflow) $display("%0t@SB underflow $%0d", $time, wb_addr);
   end
`endif
`else
   assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_d_reg_scoreboard.sv
module tb_d_reg_scoreboard;

   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [4:0]  rs_addr, rt_addr, dst_addr, wb_addr;
   logic        rs_use, rt_use, dst_we, wb_we, out_ready;
   logic [4:0]  A1, A2, out_dst;
   logic [31:0] RD1, RD2, wb_data, out_rs_val, out_rt_val;
   logic        out_valid, out_dst_we, sb_err;

   always #5 clk = ~clk;

   d_reg_scoreboard #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
      .dst_addr(dst_addr), .dst_we(dst_we), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_rs_val(out_rs_val),
      .out_rt_val(out_rt_val), .out_dst(out_dst), .out_dst_we(out_dst_we),
      .sb_err(sb_err)
   );

   int checks = 0;
   int errors = 0;

   // reference model: outstanding-write counts and the E-stage packet
   int          cnt_m [32];
   bit          ov_m, dwe_m, err_m;
   logic [31:0] rs_m, rt_m;
   logic [4:0]  dst_m;

   typedef struct {
      logic [31:0] iv, rs, rt, rsu, rtu, dst, dwe, rd1, rd2, wbwe, wba, wbd, ordy;
      logic [31:0] e_rdy, e_ov, e_rs, e_rt, e_dst;
   } vec_t;

   vec_t tab [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      bit wbf, rsh, rth, full;
      wbf  = wb_we && wb_addr != 0;
      rsh  = rs_use && rs_addr != 0 && cnt_m[rs_addr] > 0 &&
             !(wbf && wb_addr == rs_addr && cnt_m[rs_addr] == 1);
      rth  = rt_use && rt_addr != 0 && cnt_m[rt_addr] > 0 &&
             !(wbf && wb_addr == rt_addr && cnt_m[rt_addr] == 1);
      full = dst_we && dst_addr != 0 && cnt_m[dst_addr] == MAXC &&
             !(wbf && wb_addr == dst_addr);
      return !rsh && !rth && !full && (!ov_m || out_ready);
   endfunction

   task automatic model_clear();
      foreach (cnt_m[i]) cnt_m[i] = 0;
      ov_m = 0; dwe_m = 0; err_m = 0; rs_m = 0; rt_m = 0; dst_m = 0;
   endtask

   task automatic model_edge(input bit rdy);
      bit acc;
      int inc_reg, dec_reg;
      if (!reset) begin
         model_clear();
         return;
      end
      acc     = in_valid && rdy;
      inc_reg = (acc && dst_we && dst_addr != 0) ? int'(dst_addr) : -1;
      dec_reg = (wb_we && wb_addr != 0) ? int'(wb_addr) : -1;
      if (dec_reg >= 0 && cnt_m[dec_reg] == 0 && dec_reg != inc_reg) err_m = 1;
      if (inc_reg >= 0) cnt_m[inc_reg]++;
      if (dec_reg >= 0 && cnt_m[dec_reg] > 0) cnt_m[dec_reg]--;
      if (acc) begin
         ov_m  = 1;
         rs_m  = (wb_we && wb_addr == rs_addr && rs_addr != 0) ? wb_data : RD1;
         rt_m  = (wb_we && wb_addr == rt_addr && rt_addr != 0) ? wb_data : RD2;
         dst_m = dst_addr;
         dwe_m = dst_we;
      end else if (ov_m && out_ready) begin
         ov_m = 0;
      end
   endtask

   function automatic logic exp_err();
`ifdef SCOREBOARD_CHECK_EN
      return err_m;
`else
      return 1'b0;
`endif
   endfunction

   // inputs already driven; check combinational side, clock, check registered side
   task automatic tick(input bit use_tab, input vec_t v);
      bit rdy_m;
      #1;
      rdy_m = m_ready();
      chk("in_ready", 32'(in_ready), 32'(rdy_m));
      chk("A1", 32'(A1), 32'(rs_addr));
      chk("A2", 32'(A2), 32'(rt_addr));
      if (use_tab) chk("vec_in_ready", 32'(in_ready), v.e_rdy);
      @(posedge clk);
      model_edge(rdy_m);
      #2;
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      chk("out_rs_val", out_rs_val, rs_m);
      chk("out_rt_val", out_rt_val, rt_m);
      chk("out_dst", 32'(out_dst), 32'(dst_m));
      chk("out_dst_we", 32'(out_dst_we), 32'(dwe_m));
      chk("sb_err", 32'(sb_err), 32'(exp_err()));
      if (use_tab) begin
         chk("vec_out_valid", 32'(out_valid), v.e_ov);
         chk("vec_out_rs_val", out_rs_val, v.e_rs);
         chk("vec_out_rt_val", out_rt_val, v.e_rt);
         chk("vec_out_dst", 32'(out_dst), v.e_dst);
      end
   endtask

   task automatic idle();
      reset = 1; in_valid = 0; rs_addr = 0; rt_addr = 0; rs_use = 0; rt_use = 0;
      dst_addr = 0; dst_we = 0; RD1 = 0; RD2 = 0; wb_we = 0; wb_addr = 0;
      wb_data = 0; out_ready = 1;
   endtask

   initial begin
      vec_t v;
      //           iv rs rt rsu rtu dst dwe rd1     rd2     wbwe wba wbd      ordy rdy ov rs        rt      dst
      tab[0]  = '{1, 1, 2, 1, 1, 3, 1, 'h5,    'h7,    0, 0, 'h0,    1, 1, 1, 'h5,    'h7,    3};
      tab[1]  = '{1, 3, 0, 1, 0, 0, 0, 'h9,    'h0,    0, 0, 'h0,    1, 0, 0, 'h5,    'h7,    3};
      tab[2]  = '{1, 1, 2, 0, 0, 4, 1, 'h11,   'h22,   1, 3, 'h33,   1, 1, 1, 'h11,   'h22,   4};
      tab[3]  = '{1, 4, 3, 1, 1, 0, 0, 'hAA,   'hBB,   0, 0, 'h0,    1, 0, 0, 'h11,   'h22,   4};
      tab[4]  = '{1, 4, 3, 1, 1, 0, 0, 'hAA,   'hBB,   1, 4, 'hDEAD, 1, 1, 1, 'hDEAD, 'hBB,   0};
      tab[5]  = '{1, 0, 0, 1, 1, 0, 1, 'h1234, 'h5678, 1, 0, 'h55,   1, 1, 1, 'h1234, 'h5678, 0};
      tab[6]  = '{1, 0, 0, 0, 0, 5, 1, 'h61,   'h0,    0, 0, 'h0,    1, 1, 1, 'h61,   'h0,    5};
      tab[7]  = '{1, 0, 0, 0, 0, 5, 1, 'h62,   'h0,    0, 0, 'h0,    1, 1, 1, 'h62,   'h0,    5};
      tab[8]  = '{1, 0, 0, 0, 0, 5, 1, 'h63,   'h0,    0, 0, 'h0,    1, 1, 1, 'h63,   'h0,    5};
      tab[9]  = '{1, 0, 0, 0, 0, 5, 1, 'h64,   'h0,    0, 0, 'h0,    1, 0, 0, 'h63,   'h0,    5};
      tab[10] = '{1, 0, 0, 0, 0, 5, 1, 'h64,   'h0,    1, 5, 'h99,   1, 1, 1, 'h64,   'h0,    5};
      tab[11] = '{1, 5, 0, 1, 0, 0, 0, 'h70,   'h0,    1, 5, 'h98,   1, 0, 0, 'h64,   'h0,    5};
      tab[12] = '{0, 5, 0, 0, 0, 0, 0, 'h0,    'h0,    1, 5, 'h97,   1, 1, 0, 'h64,   'h0,    5};
      tab[13] = '{1, 5, 0, 1, 0, 0, 0, 'h0,    'h0,    1, 5, 'hBEEF, 1, 1, 1, 'hBEEF, 'h0,    0};
      tab[14] = '{1, 1, 2, 0, 0, 7, 1, 'h71,   'h72,   0, 0, 'h0,    0, 0, 1, 'hBEEF, 'h0,    0};
      tab[15] = '{1, 1, 2, 0, 0, 7, 1, 'h71,   'h72,   0, 0, 'h0,    0, 0, 1, 'hBEEF, 'h0,    0};
      tab[16] = '{1, 1, 2, 0, 0, 7, 1, 'h71,   'h72,   0, 0, 'h0,    1, 1, 1, 'h71,   'h72,   7};
      tab[17] = '{0, 0, 0, 0, 0, 0, 0, 'h0,    'h0,    0, 0, 'h0,    1, 1, 0, 'h71,   'h72,   7};

      idle();
      reset = 0;
      repeat (2) @(posedge clk);
      #2;
      model_clear();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_rs_val", out_rs_val, 32'd0);
      chk("rst_sb_err", 32'(sb_err), 32'd0);
      reset = 1;

      // table-driven directed vectors
      for (int i = 0; i < 18; i++) begin
         v = tab[i];
         in_valid = v.iv[0];   rs_addr = v.rs[4:0];  rt_addr = v.rt[4:0];
         rs_use = v.rsu[0];    rt_use = v.rtu[0];    dst_addr = v.dst[4:0];
         dst_we = v.dwe[0];    RD1 = v.rd1;          RD2 = v.rd2;
         wb_we = v.wbwe[0];    wb_addr = v.wba[4:0]; wb_data = v.wbd;
         out_ready = v.ordy[0];
         tick(1'b1, v);
      end

      // reset with two reservations on r6 and a packet held under backpressure
      idle();
      in_valid = 1; dst_addr = 6; dst_we = 1; RD1 = 32'h66;
      tick(1'b0, v);
      tick(1'b0, v);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      in_valid = 0; out_ready = 0; reset = 0;
      tick(1'b0, v);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_dst", 32'(out_dst), 32'd0);
      chk("mid_rst_out_dst_we", 32'(out_dst_we), 32'd0);
      chk("mid_rst_out_rs_val", out_rs_val, 32'd0);
      chk("mid_rst_out_rt_val", out_rt_val, 32'd0);
      idle();
      in_valid = 1; rs_addr = 6; rs_use = 1;
      #1;
      chk("post_rst_rs6_ready", 32'(in_ready), 32'd1);
      tick(1'b0, v);
      idle();
      wb_we = 1; wb_addr = 6; wb_data = 32'h6;
      tick(1'b0, v);
`ifdef SCOREBOARD_CHECK_EN
      chk("underflow_sb_err", 32'(sb_err), 32'd1);
`else
      chk("underflow_sb_err", 32'(sb_err), 32'd0);
`endif

      // randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         reset     = ($urandom_range(63) != 0);
         in_valid  = ($urandom_range(3) != 0);
         rs_addr   = 5'($urandom_range(5));
         rt_addr   = 5'($urandom_range(5));
         rs_use    = 1'($urandom_range(1));
         rt_use    = 1'($urandom_range(1));
         dst_addr  = 5'($urandom_range(5));
         dst_we    = ($urandom_range(3) != 0);
         RD1       = $urandom;
         RD2       = $urandom;
         wb_we     = ($urandom_range(2) == 0);
         wb_addr   = 5'($urandom_range(5));
         wb_data   = $urandom;
         out_ready = ($urandom_range(3) != 0);
         tick(1'b0, v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/d_reg_scoreboard.md
Name: d_reg_scoreboard

Overview:
- D-stage operand reader on the read side of the general register file.
- Drives the GRF read addresses and tracks pending destination writes in a per-register scoreboard.
- Stalls instructions whose sources are still outstanding.
- Bypasses the same-cycle write-back value, because the GRF only commits on the clock edge.
- Emits a registered operand packet to the E stage through a valid/ready handshake.

Parameters:
CNT_W, 2, width of each per-register pending counter; maximum outstanding writes per register = 2^CNT_W-1

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-low; reset==0 at posedge clears all state
in_valid  in  1  decoded instruction present
in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready
rs_addr  in  5  source 1 register
rt_addr  in  5  source 2 register
rs_use  in  1  source 1 read by the instruction
rt_use  in  1  source 2 read by the instruction
dst_addr  in  5  destination register
dst_we  in  1  instruction writes dst_addr
A1  out  5  GRF read address 1
A2  out  5  GRF read address 2
RD1  in  32  GRF read data 1
RD2  in  32  GRF read data 2
wb_we  in  1  write-back valid; same signal as the GRF write enable
wb_addr  in  5  write-back register; same as the GRF write address
wb_data  in  32  write-back data; same as the GRF write data
out_valid  out  1  operand packet valid
out_ready  in  1  E stage takes the packet
out_rs_val  out  32  source 1 value
out_rt_val  out  32  source 2 value
out_dst  out  5  destination register
out_dst_we  out  1  destination write enable
sb_err  out  1  scoreboard underflow flag; see Optional Feature

Behaviour:
- A1=rs_addr and A2=rt_addr, combinational.
- Scoreboard: counter cnt[r] of width CNT_W for r=1..31. Register 0 is never pending and never counted.
- rs value: wb_data if wb_we && wb_addr==rs_addr && rs_addr!=0; else RD1. rt value uses the same rule with RD2.
- wb_fire = wb_we && wb_addr!=0.
- rs hazard: rs_use && rs_addr!=0 && cnt[rs_addr]!=0, except when wb_fire && wb_addr==rs_addr && cnt[rs_addr]==1 (last writer completing; bypass used). rt hazard uses the same rule.
- Full hazard: dst_we && dst_addr!=0 && cnt[dst_addr]==max && !(wb_fire && wb_addr==dst_addr).
- in_ready = !rs_hazard && !rt_hazard && !full_hazard && (!out_valid || out_ready). in_ready is independent of in_valid.
- accept = in_valid && in_ready. On accept, at the next edge:
  - out_valid<=1.
  - out_* <= the values above.
  - if dst_we && dst_addr!=0, cnt[dst_addr]++.
- If out_valid && out_ready && !accept, out_valid<=0. out_* hold their values otherwise.
- On wb_fire, cnt[wb_addr]-- at the edge.
- Simultaneous increment and decrement of the same register leaves the count unchanged.
- Decrement with cnt==0: count stays 0 (no wrap).
- Latency: accept to out_valid is 1 cycle. Throughput is 1 per cycle with no hazards.
- Reset (reset==0): all cnt=0, out_valid=0, out_rs_val=0, out_rt_val=0, out_dst=0, out_dst_we=0, sb_err=0.
- Reset asserted mid-stall or mid-handshake discards the held packet and all reservations.

Optional Feature:
- Macro: SCOREBOARD_CHECK_EN.
- Defined:
  - A wb_fire to a register with cnt==0 (and no same-cycle increment) sets sb_err<=1, sticky until reset.
  - Prints "$time@SB underflow $%d" in simulation.
- Undefined: sb_err is constant 0, no check logic and no print.
- Scoreboard behaviour is identical in both builds.

Test Plan:
- No hazard: in rs=1, rt=2, dst=3, RD1=5, RD2=7, out_ready=1 -> next cycle out_valid=1, rs_val=5, rt_val=7, out_dst=3, cnt[3]=1.
- RAW stall: accept dst=4; next instruction rs=4 with no wb -> in_ready=0. Then wb_we=1, wb_addr=4, wb_data=0xDEAD -> in_ready=1, out_rs_val=0xDEAD, cnt[4]=0.
- $0: dst=0 then rs=0, rs_use=1 -> no stall, cnt unchanged; wb_addr=0 has no effect.
- Saturation (CNT_W=2): three accepts with dst=5, then a fourth -> in_ready=0. wb to 5 in the same cycle -> accepted, cnt[5] stays 3.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_* stable. Release out_ready -> the new packet loads in the same edge.
- Reset: cnt[6]=2, out_valid=1, reset=0 for one edge -> all outputs 0 and rs=6 no longer stalls. With SCOREBOARD_CHECK_EN, wb to 6 after reset -> sb_err=1.
